// File: rtl/aes_loader_pkg.sv
// Shared types and frame-size constants for the UART-fed AES key/plaintext loader.
package aes_loader_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int KEY_BYTES   = 16;
  localparam int PT_BYTES    = 16;
  localparam int FRAME_BYTES = KEY_BYTES + PT_BYTES;

endpackage

// File: rtl/aes_byte_buf.sv
// 16x8 byte buffer: one synchronous write port, two independent registered read ports.
module aes_byte_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic       ce0_i,
  input  logic [3:0] raddr0_i,
  output logic [7:0] q0_o,
  input  logic       ce1_i,
  input  logic [3:0] raddr1_i,
  output logic [7:0] q1_o
);

  logic [7:0] mem_q [16];
  logic [7:0] rd0_q, rd1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      // a read colliding with a write returns the previous contents
      if (ce0_i) rd0_q <= mem_q[raddr0_i];
      if (ce1_i) rd1_q <= mem_q[raddr1_i];
    end
  end

  assign q0_o = rd0_q;
  assign q1_o = rd1_q;

endmodule

// File: rtl/aes_uart_loader.sv
// Collects a 32-byte UART frame (16 key + 16 plaintext bytes) and hands it to an AES core.
// Optional inter-byte timeout is enabled with the AES_LOADER_TIMEOUT_EN macro.
//   state   | meaning
//   ST_LOAD | accepting bytes, rx_ready high
//   ST_RUN  | ap_start held high until ap_done, incoming bytes dropped
module aes_uart_loader
  import aes_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [3:0]  key_address0,
  input  logic        key_ce0,
  output logic [7:0]  key_q0,
  input  logic [3:0]  key_address1,
  input  logic        key_ce1,
  output logic [7:0]  key_q1,
  input  logic [6:0]  plain_text_address0,
  input  logic        plain_text_ce0,
  output logic        plain_text_q0,
  input  logic [6:0]  plain_text_address1,
  input  logic        plain_text_ce1,
  output logic        plain_text_q1,
  output logic        ap_start,
  input  logic        ap_done,
  output logic        frame_err,
  output logic        overrun,
  output logic [15:0] frame_count
);

  state_e      state_q, state_d;
  logic [4:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        overrun_q, overrun_d;
  logic        wr_en;
  logic [7:0]  pt_byte0, pt_byte1;
  logic [2:0]  pt_sel0_q, pt_sel1_q;

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              frame_err_q, frame_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      byte_cnt_q  <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef AES_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idle_q      <= idle_d;
      frame_err_q <= frame_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
    idle_d      = idle_q;
    frame_err_d = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (rx_valid) begin
          wr_en      = 1'b1;
          // 5-bit counter wraps 31 -> 0 on its own
          byte_cnt_d = byte_cnt_q + 5'd1;
`ifdef AES_LOADER_TIMEOUT_EN
          idle_d     = '0;
`endif
          if (byte_cnt_q == 5'(FRAME_BYTES - 1)) state_d = ST_RUN;
        end
`ifdef AES_LOADER_TIMEOUT_EN
        else if (byte_cnt_q != '0) begin
          if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            byte_cnt_d  = '0;
            idle_d      = '0;
            frame_err_d = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
`endif
      end
      ST_RUN: begin
        overrun_d = rx_valid;
        if (ap_done) begin
          state_d     = ST_LOAD;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  aes_byte_buf u_key_buf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wr_en & ~byte_cnt_q[4]),
    .waddr_i  (byte_cnt_q[3:0]),
    .wdata_i  (rx_data),
    .ce0_i    (key_ce0),
    .raddr0_i (key_address0),
    .q0_o     (key_q0),
    .ce1_i    (key_ce1),
    .raddr1_i (key_address1),
    .q1_o     (key_q1)
  );

  aes_byte_buf u_pt_buf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wr_en & byte_cnt_q[4]),
    .waddr_i  (byte_cnt_q[3:0]),
    .wdata_i  (rx_data),
    .ce0_i    (plain_text_ce0),
    .raddr0_i (plain_text_address0[6:3]),
    .q0_o     (pt_byte0),
    .ce1_i    (plain_text_ce1),
    .raddr1_i (plain_text_address1[6:3]),
    .q1_o     (pt_byte1)
  );

  // bit selects are captured alongside the byte read so the output holds with ce low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pt_sel0_q <= '0;
      pt_sel1_q <= '0;
    end else begin
      if (plain_text_ce0) pt_sel0_q <= plain_text_address0[2:0];
      if (plain_text_ce1) pt_sel1_q <= plain_text_address1[2:0];
    end
  end

  assign plain_text_q0 = pt_byte0[pt_sel0_q];
  assign plain_text_q1 = pt_byte1[pt_sel1_q];
  assign rx_ready      = (state_q == ST_LOAD);
  assign ap_start      = (state_q == ST_RUN);
  assign overrun       = overrun_q;
  assign frame_count   = frame_cnt_q;
`ifdef AES_LOADER_TIMEOUT_EN
  assign frame_err     = frame_err_q;
`else
  assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_aes_uart_loader.sv
// Self-checking bench for aes_uart_loader: directed frame, read-port table, random frames,
// timeout boundary, read hold and reset during RUN.
module tb_aes_uart_loader;

  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [3:0]  key_address0 = '0, key_address1 = '0;
  logic        key_ce0 = 1'b0, key_ce1 = 1'b0;
  logic [7:0]  key_q0, key_q1;
  logic [6:0]  plain_text_address0 = '0, plain_text_address1 = '0;
  logic        plain_text_ce0 = 1'b0, plain_text_ce1 = 1'b0;
  logic        plain_text_q0, plain_text_q1;
  logic        ap_start;
  logic        ap_done = 1'b0;
  logic        frame_err, overrun;
  logic [15:0] frame_count;

  aes_uart_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .key_address0(key_address0), .key_ce0(key_ce0), .key_q0(key_q0),
    .key_address1(key_address1), .key_ce1(key_ce1), .key_q1(key_q1),
    .plain_text_address0(plain_text_address0), .plain_text_ce0(plain_text_ce0),
    .plain_text_q0(plain_text_q0),
    .plain_text_address1(plain_text_address1), .plain_text_ce1(plain_text_ce1),
    .plain_text_q1(plain_text_q1),
    .ap_start(ap_start), .ap_done(ap_done), .frame_err(frame_err), .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int ov_cnt = 0, fe_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  // reference model: byte arrays filled in arrival order, frame position, completed frames
  logic [7:0] m_key [16];
  logic [7:0] m_pt  [16];
  int         m_pos = 0;
  int         m_fc  = 0;

  typedef struct {
    bit         pt;
    bit         port;
    logic [6:0] addr;
    logic [7:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) begin
      m_key[i] = '0;
      m_pt[i]  = '0;
    end
    m_pos = 0;
    m_fc  = 0;
  endtask

  function automatic logic [7:0] m_exp(input bit pt, input logic [6:0] a);
    logic [7:0] b;
    if (!pt) return m_key[a[3:0]];
    b = m_pt[a[6:3]];
    return {7'd0, b[a[2:0]]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    if (m_pos < 16) m_key[m_pos] = b;
    else            m_pt[m_pos-16] = b;
    m_pos = (m_pos + 1) % 32;
  endtask

  // sends the remaining n bytes of a frame and checks the hand-off to RUN
  task automatic send_n(input int n, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) step();
      if (i == n - 1) chk("ap_start_before_last", {31'd0, ap_start}, 32'd0);
      send_byte(8'($urandom));
    end
    chk("ap_start_after_last", {31'd0, ap_start}, 32'd1);
    chk("rx_ready_in_run", {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic rd(input bit pt, input bit port, input logic [6:0] a, output logic [7:0] got);
    if (!pt) begin
      if (!port) begin key_address0 = a[3:0]; key_ce0 = 1'b1; end
      else       begin key_address1 = a[3:0]; key_ce1 = 1'b1; end
    end else begin
      if (!port) begin plain_text_address0 = a; plain_text_ce0 = 1'b1; end
      else       begin plain_text_address1 = a; plain_text_ce1 = 1'b1; end
    end
    step();
    if (!pt) got = port ? key_q1 : key_q0;
    else     got = {7'd0, (port ? plain_text_q1 : plain_text_q0)};
    key_ce0 = 1'b0; key_ce1 = 1'b0; plain_text_ce0 = 1'b0; plain_text_ce1 = 1'b0;
  endtask

  task automatic rand_reads(input int n);
    logic [7:0] got;
    bit         pt, port;
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      pt   = 1'($urandom);
      port = 1'($urandom);
      a    = 7'($urandom);
      rd(pt, port, a, got);
      chk(pt ? "rand_pt_read" : "rand_key_read", {24'd0, got}, {24'd0, m_exp(pt, a)});
    end
  endtask

  task automatic finish_run();
    repeat ($urandom_range(1, 10)) step();
    chk("ap_start_held", {31'd0, ap_start}, 32'd1);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    m_fc = (m_fc + 1) % 65536;
    chk("ap_start_drop", {31'd0, ap_start}, 32'd0);
    chk("rx_ready_back", {31'd0, rx_ready}, 32'd1);
    chk("frame_count", {16'd0, frame_count}, m_fc);
  endtask

  initial begin
    logic [7:0] got;
    int         start_cyc;
    int         n_rest;

    m_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_ap_start", {31'd0, ap_start}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_key_q0", {24'd0, key_q0}, 32'd0);
    chk("rst_pt_q1", {31'd0, plain_text_q1}, 32'd0);
    chk("rst_pulses", {30'd0, overrun, frame_err}, 32'd0);

    // directed frame: key 00..0F, plaintext 00 11 .. FF, back to back
    step();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("dir_ap_start_pre", {31'd0, ap_start}, 32'd0);
      send_byte(i < 16 ? 8'(i) : 8'((i - 16) * 17));
    end
    start_cyc = cyc;
    chk("dir_ap_start_rise", {31'd0, ap_start}, 32'd1);
    chk("dir_rx_ready_low", {31'd0, rx_ready}, 32'd0);

    // byte in RUN: dropped, single overrun pulse
    ov_cnt   = 0;
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
    step();
    chk("overrun_once", ov_cnt, 32'd1);

    tbl[0] = '{1'b0, 1'b0, 7'd5,   8'h05};
    tbl[1] = '{1'b1, 1'b1, 7'd9,   8'h00};
    tbl[2] = '{1'b0, 1'b1, 7'd15,  8'h0F};
    tbl[3] = '{1'b1, 1'b0, 7'd8,   8'h01};
    tbl[4] = '{1'b1, 1'b1, 7'd127, 8'h01};
    tbl[5] = '{1'b1, 1'b0, 7'd0,   8'h00};
    tbl[6] = '{1'b0, 1'b0, 7'd0,   8'h00};
    tbl[7] = '{1'b1, 1'b0, 7'd28,  8'h01};
    for (int i = 8; i < 12; i++) begin
      tbl[i].pt   = 1'($urandom);
      tbl[i].port = 1'($urandom);
      tbl[i].addr = 7'($urandom);
      tbl[i].exp  = m_exp(tbl[i].pt, tbl[i].addr);
    end
    for (int i = 0; i < 12; i++) begin
      rd(tbl[i].pt, tbl[i].port, tbl[i].addr, got);
      chk(tbl[i].pt ? "tbl_pt_read" : "tbl_key_read", {24'd0, got}, {24'd0, tbl[i].exp});
    end

    // ap_done 40 cycles after ap_start rose
    while (cyc - start_cyc < 39) step();
    chk("ap_start_at_39", {31'd0, ap_start}, 32'd1);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    m_fc = 1;
    chk("done_ap_start_low", {31'd0, ap_start}, 32'd0);
    chk("done_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("done_frame_count", {16'd0, frame_count}, 32'd1);

    // ap_done in LOAD is ignored
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    chk("load_done_ignored_rdy", {31'd0, rx_ready}, 32'd1);
    chk("load_done_ignored_fc", {16'd0, frame_count}, 32'd1);

    // random frames with gaps, random reads in RUN and after
    for (int f = 0; f < 3; f++) begin
      send_n(32, 5);
      rand_reads(10);
      finish_run();
      rand_reads(6);
    end

    // idle of TO-1 cycles must not abort a partial frame
    fe_cnt = 0;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    repeat (TO - 1) step();
    send_n(25, 0);
    chk("no_timeout_at_limit_minus1", fe_cnt, 32'd0);
    finish_run();

    // idle past the limit
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    fe_cnt = 0;
    repeat (TO + 10) step();
`ifdef AES_LOADER_TIMEOUT_EN
    chk("timeout_frame_err_once", fe_cnt, 32'd1);
    m_pos  = 0;
    n_rest = 32;
`else
    chk("no_timeout_build", fe_cnt, 32'd0);
    n_rest = 25;
`endif
    chk("timeout_still_load", {31'd0, rx_ready}, 32'd1);
    send_n(n_rest, 3);
    for (int i = 0; i < 16; i++) begin
      rd(1'b0, 1'($urandom), 7'(i), got);
      chk("post_timeout_key", {24'd0, got}, {24'd0, m_key[i]});
    end
    finish_run();

    // simultaneous reads, then ce low with new addresses: outputs hold
    key_address0 = 4'd0; key_address1 = 4'd15; key_ce0 = 1'b1; key_ce1 = 1'b1;
    plain_text_address0 = 7'd3; plain_text_address1 = 7'd125;
    plain_text_ce0 = 1'b1; plain_text_ce1 = 1'b1;
    step();
    key_ce0 = 1'b0; key_ce1 = 1'b0; plain_text_ce0 = 1'b0; plain_text_ce1 = 1'b0;
    chk("dual_key_q0", {24'd0, key_q0}, {24'd0, m_key[0]});
    chk("dual_key_q1", {24'd0, key_q1}, {24'd0, m_key[15]});
    chk("dual_pt_q0", {31'd0, plain_text_q0}, {24'd0, m_exp(1'b1, 7'd3)});
    chk("dual_pt_q1", {31'd0, plain_text_q1}, {24'd0, m_exp(1'b1, 7'd125)});
    key_address0 = 4'd7; key_address1 = 4'd8;
    plain_text_address0 = 7'd64; plain_text_address1 = 7'd17;
    step();
    step();
    chk("hold_key_q0", {24'd0, key_q0}, {24'd0, m_key[0]});
    chk("hold_key_q1", {24'd0, key_q1}, {24'd0, m_key[15]});
    chk("hold_pt_q0", {31'd0, plain_text_q0}, {24'd0, m_exp(1'b1, 7'd3)});
    chk("hold_pt_q1", {31'd0, plain_text_q1}, {24'd0, m_exp(1'b1, 7'd125)});

    // reset three cycles into RUN
    send_n(32, 2);
    key_address0 = 4'd2; key_ce0 = 1'b1;
    step();
    key_ce0 = 1'b0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk("rstrun_ap_start", {31'd0, ap_start}, 32'd0);
    chk("rstrun_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rstrun_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rstrun_key_q0", {24'd0, key_q0}, 32'd0);
    chk("rstrun_pulses", {30'd0, overrun, frame_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    step();
    rand_reads(6);
    send_n(32, 2);
    rand_reads(6);
    finish_run();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
